// File: rtl/imem_loader_if.sv
// Pad-side byte stream and instruction-memory write bus of the load controller.
// The slave modport is the loader; the master modport is the pad ring / core side.
interface imem_loader_if;
  logic        load_mode;
  logic        byte_strobe;
  logic [7:0]  byte_in;
  logic [9:0]  imem_write_adr;
  logic [39:0] imem_in;
  logic        imem_write;
  logic        core_reset;
  logic [9:0]  load_count;
  logic        frame_error;

  modport slave (
    input  load_mode, byte_strobe, byte_in,
    output imem_write_adr, imem_in, imem_write, core_reset, load_count, frame_error
  );

  modport master (
    output load_mode, byte_strobe, byte_in,
    input  imem_write_adr, imem_in, imem_write, core_reset, load_count, frame_error
  );
endinterface

// File: rtl/imem_loader.sv
// Byte-serial instruction-memory loader: synchronises the pad strobe and mode level,
// assembles a 10-bit start address plus 40-bit words, and emits one-cycle writes.
module imem_loader (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_HI = 3'd1,
    ADDR_LO = 3'd2,
    DATA    = 3'd3,
    WRITE   = 3'd4
  } state_t;

  logic [1:0]  lm_sync_q;
  logic [1:0]  strobe_sync_q;
  logic        strobe_edge_q;
  logic        lm_prev_q;
  logic        lm_s;
  logic        strobe_s;
  logic        byte_ev;

  state_t      state_q, state_d;
  logic [9:0]  addr_q, addr_d;
  logic [39:0] word_q, word_d;
  logic [2:0]  idx_q, idx_d;
  logic [9:0]  count_q, count_d;
  logic        ferr_q, ferr_d;
  logic        wr_q, wr_d;
  logic        core_reset_q, core_reset_d;

  assign lm_s     = lm_sync_q[1];
  assign strobe_s = strobe_sync_q[1];
  // byte_in is read straight from the pad: it is held for several cycles after the strobe.
  assign byte_ev  = strobe_s & ~strobe_edge_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lm_sync_q     <= 2'b00;
      strobe_sync_q <= 2'b00;
      strobe_edge_q <= 1'b0;
      lm_prev_q     <= 1'b0;
      state_q       <= IDLE;
      addr_q        <= '0;
      word_q        <= '0;
      idx_q         <= '0;
      count_q       <= '0;
      ferr_q        <= 1'b0;
      wr_q          <= 1'b0;
      core_reset_q  <= 1'b1;
    end else begin
      lm_sync_q     <= {lm_sync_q[0], bus.load_mode};
      strobe_sync_q <= {strobe_sync_q[0], bus.byte_strobe};
      strobe_edge_q <= strobe_s;
      lm_prev_q     <= lm_s;
      state_q       <= state_d;
      addr_q        <= addr_d;
      word_q        <= word_d;
      idx_q         <= idx_d;
      count_q       <= count_d;
      ferr_q        <= ferr_d;
      wr_q          <= wr_d;
      core_reset_q  <= core_reset_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    word_d       = word_q;
    idx_d        = idx_q;
    count_d      = count_q;
    ferr_d       = ferr_q;
    wr_d         = 1'b0;
    core_reset_d = lm_s | (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (lm_s && !lm_prev_q) begin
          state_d = ADDR_HI;
          count_d = '0;
          ferr_d  = 1'b0;
        end
      end
      ADDR_HI: begin
        if (!lm_s) begin
          state_d = IDLE;
        end else if (byte_ev) begin
          addr_d[9:8] = bus.byte_in[1:0];
          state_d     = ADDR_LO;
        end
      end
      ADDR_LO: begin
        if (!lm_s) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
        end else if (byte_ev) begin
          addr_d[7:0] = bus.byte_in;
          idx_d       = 3'd0;
          state_d     = DATA;
        end
      end
      DATA: begin
        // Losing load mode on a word boundary is a clean exit; mid-word it is a frame error.
        if (!lm_s) begin
          state_d = IDLE;
          if (idx_q != 3'd0) ferr_d = 1'b1;
        end else if (byte_ev) begin
          word_d = {word_q[31:0], bus.byte_in};
          if (idx_q == 3'd4) begin
            idx_d   = 3'd0;
            state_d = WRITE;
            wr_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      WRITE: begin
        // The write always completes; only afterwards may a dropped mode take effect.
        addr_d  = addr_q + 10'd1;
        count_d = count_q + 10'd1;
        idx_d   = 3'd0;
        state_d = lm_s ? DATA : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.imem_write_adr = addr_q;
  assign bus.imem_in        = word_q;
  assign bus.imem_write     = wr_q;
  assign bus.core_reset     = core_reset_q;
  assign bus.load_count     = count_q;
  assign bus.frame_error    = ferr_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: a byte-stream reference model predicts writes,
// counters and frame errors for each load session.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset;
  imem_loader_if lif ();

  imem_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (lif)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [49:0] got_q[$];
  logic [49:0] exp_q[$];
  logic [7:0]  stim_q[$];
  int          exp_count;
  int          exp_adr;
  logic        exp_err;

  always @(negedge clk) begin
    if (lif.imem_write === 1'b1) begin
      got_q.push_back({lif.imem_write_adr, lif.imem_in});
      $display("write adr=%h data=%h", lif.imem_write_adr, lif.imem_in);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    lif.byte_in     = b;
    lif.byte_strobe = 1'b1;
    cycles(4);
    lif.byte_strobe = 1'b0;
    cycles(4);
  endtask

  task automatic send_stim();
    for (int i = 0; i < stim_q.size(); i++) send_byte(stim_q[i]);
    cycles(4);
  endtask

  task automatic enter_load();
    lif.load_mode = 1'b1;
    cycles(4);
  endtask

  task automatic leave_load();
    lif.load_mode = 1'b0;
    cycles(6);
  endtask

  // Reference: byte 0 gives addr[9:8], byte 1 addr[7:0], then every 5 bytes form one word.
  task automatic model_frame();
    int n, words, base;
    logic [39:0] w;
    exp_q.delete();
    n       = stim_q.size();
    exp_err = (n == 1) || (n >= 2 && ((n - 2) % 5) != 0);
    words   = (n >= 2) ? (n - 2) / 5 : 0;
    base    = (n >= 2) ? (int'(stim_q[0][1:0]) * 256 + int'(stim_q[1])) : 0;
    for (int i = 0; i < words; i++) begin
      w = '0;
      for (int j = 0; j < 5; j++) w = w * 40'd256 + 40'(stim_q[2 + 5 * i + j]);
      exp_q.push_back({10'((base + i) % 1024), w});
    end
    exp_count = words % 1024;
    exp_adr   = (base + words) % 1024;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    lif.load_mode = 1'b0;
    lif.byte_strobe = 1'b0;
    lif.byte_in = 8'h00;
    cycles(3);
    total++; if (lif.imem_write !== 1'b0) $display("FAIL rst_write: got %b want 0", lif.imem_write); else passed++;
    total++; if (lif.imem_write_adr !== 10'h000) $display("FAIL rst_adr: got %h want 000", lif.imem_write_adr); else passed++;
    total++; if (lif.imem_in !== 40'h0) $display("FAIL rst_data: got %h want 0", lif.imem_in); else passed++;
    total++; if (lif.core_reset !== 1'b1) $display("FAIL rst_core_reset: got %b want 1", lif.core_reset); else passed++;
    total++; if (lif.load_count !== 10'd0) $display("FAIL rst_count: got %0d want 0", lif.load_count); else passed++;
    total++; if (lif.frame_error !== 1'b0) $display("FAIL rst_ferr: got %b want 0", lif.frame_error); else passed++;
    reset = 1'b0;
    cycles(3);
    total++; if (lif.core_reset !== 1'b0) $display("FAIL rst_release_core_reset: got %b want 0", lif.core_reset); else passed++;
  endtask

  task automatic test_single_word();
    got_q.delete();
    stim_q = '{8'h01, 8'h23, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    enter_load();
    total++; if (lif.core_reset !== 1'b1) $display("FAIL single_core_reset_load: got %b want 1", lif.core_reset); else passed++;
    send_stim();
    total++; if (got_q.size() != 1) $display("FAIL single_nwrites: got %0d want 1", got_q.size()); else passed++;
    if (got_q.size() >= 1) begin
      total++; if (got_q[0] !== {10'h123, 40'h1122334455}) $display("FAIL single_write: got %h want %h", got_q[0], {10'h123, 40'h1122334455}); else passed++;
    end
    total++; if (lif.load_count !== 10'd1) $display("FAIL single_count: got %0d want 1", lif.load_count); else passed++;
    total++; if (lif.imem_write_adr !== 10'h124) $display("FAIL single_next_adr: got %h want 124", lif.imem_write_adr); else passed++;
    total++; if (lif.imem_in !== 40'h1122334455) $display("FAIL single_data_hold: got %h want 1122334455", lif.imem_in); else passed++;
    leave_load();
    total++; if (lif.core_reset !== 1'b0) $display("FAIL single_core_reset_exit: got %b want 0", lif.core_reset); else passed++;
    total++; if (lif.frame_error !== 1'b0) $display("FAIL single_ferr: got %b want 0", lif.frame_error); else passed++;
  endtask

  task automatic test_burst_wrap();
    got_q.delete();
    stim_q = '{8'h03, 8'hFF};
    for (int i = 0; i < 10; i++) stim_q.push_back(8'($urandom));
    model_frame();
    enter_load();
    send_stim();
    total++; if (got_q.size() != 2) $display("FAIL burst_nwrites: got %0d want 2", got_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) $display("FAIL burst_write%0d: got %h want %h", i, got_q[i], exp_q[i]); else passed++;
    end
    if (got_q.size() == 2) begin
      total++; if (got_q[1][49:40] !== 10'h000) $display("FAIL burst_wrap_adr: got %h want 000", got_q[1][49:40]); else passed++;
    end
    total++; if (lif.load_count !== 10'd2) $display("FAIL burst_count: got %0d want 2", lif.load_count); else passed++;
    total++; if (lif.frame_error !== 1'b0) $display("FAIL burst_ferr: got %b want 0", lif.frame_error); else passed++;
  endtask

  task automatic test_abort();
    leave_load();
    got_q.delete();
    stim_q = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    enter_load();
    total++; if (lif.load_count !== 10'd0) $display("FAIL abort_entry_count: got %0d want 0", lif.load_count); else passed++;
    send_stim();
    leave_load();
    total++; if (got_q.size() != 0) $display("FAIL abort_nwrites: got %0d want 0", got_q.size()); else passed++;
    total++; if (lif.frame_error !== 1'b1) $display("FAIL abort_ferr: got %b want 1", lif.frame_error); else passed++;
    total++; if (lif.core_reset !== 1'b0) $display("FAIL abort_core_reset: got %b want 0", lif.core_reset); else passed++;
    enter_load();
    total++; if (lif.frame_error !== 1'b0) $display("FAIL reentry_ferr: got %b want 0", lif.frame_error); else passed++;
    total++; if (lif.load_count !== 10'd0) $display("FAIL reentry_count: got %0d want 0", lif.load_count); else passed++;
    leave_load();
    total++; if (lif.frame_error !== 1'b0) $display("FAIL addr_hi_exit_ferr: got %b want 0", lif.frame_error); else passed++;
  endtask

  task automatic test_strobe_idle();
    got_q.delete();
    for (int i = 0; i < 7; i++) send_byte(8'($urandom));
    total++; if (got_q.size() != 0) $display("FAIL idle_nwrites: got %0d want 0", got_q.size()); else passed++;
    total++; if (lif.core_reset !== 1'b0) $display("FAIL idle_core_reset: got %b want 0", lif.core_reset); else passed++;
    total++; if (lif.frame_error !== 1'b0) $display("FAIL idle_ferr: got %b want 0", lif.frame_error); else passed++;
  endtask

  task automatic test_reset_mid_word();
    got_q.delete();
    enter_load();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    reset = 1'b1;
    cycles(2);
    total++; if (lif.imem_write_adr !== 10'h000) $display("FAIL midrst_adr: got %h want 000", lif.imem_write_adr); else passed++;
    total++; if (lif.imem_in !== 40'h0) $display("FAIL midrst_data: got %h want 0", lif.imem_in); else passed++;
    total++; if (lif.core_reset !== 1'b1) $display("FAIL midrst_core_reset: got %b want 1", lif.core_reset); else passed++;
    total++; if (lif.load_count !== 10'd0) $display("FAIL midrst_count: got %0d want 0", lif.load_count); else passed++;
    reset = 1'b0;
    cycles(4);
    stim_q.delete();
    for (int i = 0; i < 7; i++) stim_q.push_back(8'($urandom));
    model_frame();
    send_stim();
    total++; if (got_q.size() != 1) $display("FAIL midrst_nwrites: got %0d want 1", got_q.size()); else passed++;
    if (got_q.size() >= 1) begin
      total++; if (got_q[0] !== exp_q[0]) $display("FAIL midrst_write: got %h want %h", got_q[0], exp_q[0]); else passed++;
    end
    leave_load();
  endtask

  task automatic test_upper_addr();
    got_q.delete();
    stim_q = '{8'hFE, 8'h10};
    for (int i = 0; i < 5; i++) stim_q.push_back(8'($urandom));
    model_frame();
    enter_load();
    send_stim();
    total++; if (got_q.size() != 1) $display("FAIL upper_nwrites: got %0d want 1", got_q.size()); else passed++;
    if (got_q.size() >= 1) begin
      total++; if (got_q[0][49:40] !== 10'h210) $display("FAIL upper_adr: got %h want 210", got_q[0][49:40]); else passed++;
      total++; if (got_q[0] !== exp_q[0]) $display("FAIL upper_write: got %h want %h", got_q[0], exp_q[0]); else passed++;
    end
    leave_load();
  endtask

  task automatic test_random_frames();
    int n;
    for (int f = 0; f < 12; f++) begin
      got_q.delete();
      stim_q.delete();
      n = $urandom_range(0, 17);
      for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
      model_frame();
      enter_load();
      send_stim();
      total++; if (got_q.size() != exp_q.size()) $display("FAIL rand%0d_nwrites: got %0d want %0d", f, got_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        total++; if (got_q[i] !== exp_q[i]) $display("FAIL rand%0d_write%0d: got %h want %h", f, i, got_q[i], exp_q[i]); else passed++;
      end
      total++; if (lif.load_count !== 10'(exp_count)) $display("FAIL rand%0d_count: got %0d want %0d", f, lif.load_count, exp_count); else passed++;
      if (n >= 2) begin
        total++; if (lif.imem_write_adr !== 10'(exp_adr)) $display("FAIL rand%0d_adr: got %h want %h", f, lif.imem_write_adr, 10'(exp_adr)); else passed++;
      end
      leave_load();
      total++; if (lif.frame_error !== exp_err) $display("FAIL rand%0d_ferr: got %b want %b", f, lif.frame_error, exp_err); else passed++;
      total++; if (lif.core_reset !== 1'b0) $display("FAIL rand%0d_core_reset: got %b want 0", f, lif.core_reset); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_burst_wrap();
    test_abort();
    test_strobe_idle();
    test_reset_mid_word();
    test_upper_addr();
    test_random_frames();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
